// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer/response encodings, the slave FSM
// state type and the address legality check.
package ahb_pkg;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_BUSY   = 2'b01;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } slv_state_e;

  // Unaligned byte offset, or any bit set above the word-address field.
  function automatic logic addr_err(input logic [31:0] haddr, input int unsigned addr_w);
    addr_err = (haddr[1:0] != 2'b00) || ((haddr >> (addr_w + 32'd2)) != 32'd0);
  endfunction

endpackage

// File: rtl/ahb_slave_sram.sv
// Word-wide storage for the AHB slave: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module ahb_slave_sram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [1 << ADDR_W];

  // Write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite word-addressed memory slave with configurable OKAY wait states
// and a two-cycle ERROR response for unaligned or out-of-range addresses.
module ahb_slave_mem #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);
  import ahb_pkg::*;

  localparam logic [3:0] WS_INIT = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  slv_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              open_s, accept_s, err_s, commit_s, fwd_s;
  logic [ADDR_W-1:0] haddr_word_s, raddr_s;
  logic [31:0]       mem_rdata_s;
  logic              readyout_s, resp_s;

  assign haddr_word_s = HADDR[ADDR_W+1:2];
  assign err_s        = addr_err(HADDR, ADDR_W);
  // Address phases are only sampled in states whose data phase can close this cycle.
  assign open_s       = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
  assign accept_s     = open_s && HSEL && HTRANS[1] && HREADY;
  assign commit_s     = (state_q == S_DATA) && write_q;

  // A read that finishes its wait states uses the captured address; otherwise the live one.
  assign raddr_s = (state_q == S_WAIT) ? addr_q : haddr_word_s;
  assign fwd_s   = commit_s && (addr_q == raddr_s);

  ahb_slave_sram #(.ADDR_W(ADDR_W)) u_sram (
    .clk_i   (HCLK),
    .we_i    (commit_s),
    .waddr_i (addr_q),
    .wdata_i (HWDATA),
    .raddr_i (raddr_s),
    .rdata_o (mem_rdata_s)
  );

  // Next-state, wait counter and address/control capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    if (accept_s) begin
      addr_d  = haddr_word_s;
      write_d = HWRITE;
    end else begin
      addr_d  = addr_q;
      write_d = write_q;
    end
    case (state_q)
      S_IDLE, S_DATA, S_ERR2: begin
        if (!accept_s) begin
          state_d = S_IDLE;
        end else if (err_s) begin
          state_d = S_ERR1;
        end else if (WAIT_STATES == 0) begin
          state_d = S_DATA;
        end else begin
          state_d = S_WAIT;
          cnt_d   = WS_INIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  // Read data loads on the edge entering the final data cycle; forwarding covers a same-edge write.
  always_comb begin
    rdata_d = rdata_q;
    if ((state_d == S_DATA) && !write_d) begin
      rdata_d = fwd_s ? HWDATA : mem_rdata_s;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Response decode from the registered state.
  always_comb begin
    readyout_s = 1'b1;
    resp_s     = HRESP_OKAY;
    case (state_q)
      S_IDLE: begin readyout_s = 1'b1; resp_s = HRESP_OKAY;  end
      S_WAIT: begin readyout_s = 1'b0; resp_s = HRESP_OKAY;  end
      S_DATA: begin readyout_s = 1'b1; resp_s = HRESP_OKAY;  end
      S_ERR1: begin readyout_s = 1'b0; resp_s = HRESP_ERROR; end
      S_ERR2: begin readyout_s = 1'b1; resp_s = HRESP_ERROR; end
      default: begin readyout_s = 1'b1; resp_s = HRESP_OKAY; end
    endcase
  end

  // State registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
    end
  end

  assign HRDATA    = rdata_q;
  assign HREADYOUT = readyout_s;
  assign HRESP     = resp_s;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Self-checking bench: three slaves (0, 2 and 3 wait states) on one bus,
// checked cycle by cycle against a transfer-level reference model.
module tb_ahb_slave_mem;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        write;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  logic        HCLK;
  logic        HRESETn;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  hsel;
  logic        HREADY;
  int          sel;
  logic [31:0] hrdata    [3];
  logic        hreadyout [3];
  logic        hresp     [3];

  logic [31:0] model [3][256];
  bit          known [3][256];
  int          checks;
  int          errors;

  assign HREADY = hreadyout[sel];

  ahb_slave_mem #(.ADDR_W(8), .WAIT_STATES(0)) dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[0]), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(hrdata[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]));

  ahb_slave_mem #(.ADDR_W(8), .WAIT_STATES(2)) dut1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[1]), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(hrdata[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]));

  ahb_slave_mem #(.ADDR_W(8), .WAIT_STATES(3)) dut2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[2]), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(hrdata[2]), .HREADYOUT(hreadyout[2]), .HRESP(hresp[2]));

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int ws_of(input int d);
    case (d)
      0:       return 0;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  function automatic xfer_t mk(input logic s, input logic [1:0] t, input logic w,
                               input logic [31:0] a, input logic [31:0] dd);
    xfer_t x;
    x.sel = s; x.trans = t; x.write = w; x.addr = a; x.data = dd;
    return x;
  endfunction

  // Plays a transfer list on slave d; each data phase is checked against its expected shape.
  task automatic run(input int d, input xfer_t q[$]);
    bit          dp_act, dp_err, dp_wr;
    logic [7:0]  dp_word;
    logic [31:0] dp_data;
    int          len;
    logic        exp_rdy, exp_rsp;
    dp_act = 0; dp_err = 0; dp_wr = 0; dp_word = 8'd0; dp_data = 32'd0;
    sel = d;
    for (int i = 0; i <= q.size(); i++) begin
      hsel = 3'b000;
      if (i < q.size()) begin
        hsel[d] = q[i].sel; HTRANS = q[i].trans; HWRITE = q[i].write; HADDR = q[i].addr;
      end else begin
        HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'd0;
      end
      HWDATA = (dp_act && dp_wr) ? dp_data : $urandom;
      len = !dp_act ? 1 : (dp_err ? 2 : ws_of(d) + 1);
      for (int k = 0; k < len; k++) begin
        @(negedge HCLK);
        exp_rdy = (k == len - 1);
        exp_rsp = dp_act && dp_err;
        checks++;
        if (hreadyout[d] !== exp_rdy || hresp[d] !== exp_rsp) begin
          errors++;
          $display("FAIL phase dut%0d xfer%0d cyc%0d: ready/resp=%b/%b expected %b/%b",
                   d, i, k, hreadyout[d], hresp[d], exp_rdy, exp_rsp);
        end
        if (exp_rdy && dp_act && !dp_err && !dp_wr) begin
          checks++;
          if (hrdata[d] !== model[d][dp_word]) begin
            errors++;
            $display("FAIL rdata dut%0d word 0x%0h: got 0x%08h expected 0x%08h",
                     d, dp_word, hrdata[d], model[d][dp_word]);
          end
        end
        @(posedge HCLK); #1;
      end
      if (dp_act && !dp_err && dp_wr) begin
        model[d][dp_word] = dp_data;
        known[d][dp_word] = 1'b1;
      end
      if (i < q.size()) begin
        dp_act  = q[i].sel && q[i].trans[1];
        dp_err  = (q[i].addr[1:0] != 2'b00) || (q[i].addr >= 32'h400);
        dp_wr   = q[i].write;
        dp_word = q[i].addr[9:2];
        dp_data = q[i].data;
      end
    end
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (hreadyout[d] !== 1'b1 || hresp[d] !== 1'b0 || hrdata[d] !== 32'd0) begin
        errors++;
        $display("FAIL reset dut%0d: ready/resp/rdata=%b/%b/0x%08h expected 1/0/0x00000000",
                 d, hreadyout[d], hresp[d], hrdata[d]);
      end
    end
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
  endtask

  task automatic test_basic();
    xfer_t q[$];
    q.push_back(mk(1'b1, 2'b10, 1'b1, 32'h1F4, 32'hDEADBEEF));
    q.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0,   32'h0));
    q.push_back(mk(1'b1, 2'b10, 1'b0, 32'h1F4, 32'h0));
    run(0, q);
  endtask

  task automatic test_forward();
    xfer_t q[$];
    q.push_back(mk(1'b1, 2'b10, 1'b1, 32'h1F4, 32'h12345678));
    q.push_back(mk(1'b1, 2'b10, 1'b0, 32'h1F4, 32'h0));
    run(0, q);
  endtask

  task automatic test_wait();
    xfer_t q[$];
    q.push_back(mk(1'b1, 2'b10, 1'b1, 32'h1F8, 32'hA5A5A5A5));
    q.push_back(mk(1'b1, 2'b10, 1'b0, 32'h1F8, 32'h0));
    run(1, q);
  endtask

  task automatic test_burst();
    xfer_t q[$];
    q.push_back(mk(1'b1, 2'b10, 1'b1, 32'h1F4, 32'd1));
    q.push_back(mk(1'b1, 2'b11, 1'b1, 32'h1F8, 32'd2));
    q.push_back(mk(1'b1, 2'b01, 1'b1, 32'h1FC, 32'd99));
    q.push_back(mk(1'b1, 2'b11, 1'b1, 32'h1FC, 32'd3));
    q.push_back(mk(1'b1, 2'b11, 1'b1, 32'h200, 32'd4));
    q.push_back(mk(1'b1, 2'b10, 1'b0, 32'h1F4, 32'd0));
    q.push_back(mk(1'b1, 2'b11, 1'b0, 32'h1F8, 32'd0));
    q.push_back(mk(1'b1, 2'b11, 1'b0, 32'h1FC, 32'd0));
    q.push_back(mk(1'b1, 2'b11, 1'b0, 32'h200, 32'd0));
    run(1, q);
  endtask

  task automatic test_error();
    xfer_t q[$];
    q.push_back(mk(1'b1, 2'b10, 1'b1, 32'h000, 32'h0BADF00D));
    q.push_back(mk(1'b1, 2'b10, 1'b1, 32'h1F4, 32'h55AA55AA));
    q.push_back(mk(1'b1, 2'b10, 1'b1, 32'h400, 32'hFFFFFFFF));
    q.push_back(mk(1'b1, 2'b10, 1'b1, 32'h1F6, 32'hFFFFFFFF));
    q.push_back(mk(1'b1, 2'b10, 1'b0, 32'h000, 32'h0));
    q.push_back(mk(1'b1, 2'b10, 1'b0, 32'h1F4, 32'h0));
    run(0, q);
  endtask

  task automatic test_reset_mid();
    xfer_t q[$];
    q.push_back(mk(1'b1, 2'b10, 1'b1, 32'h1F4, 32'h11111111));
    q.push_back(mk(1'b1, 2'b10, 1'b0, 32'h1F4, 32'h0));
    run(2, q);
    sel = 2;
    hsel = 3'b100; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h1F4;
    @(posedge HCLK); #1;
    hsel = 3'b000; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'hCAFEF00D;
    @(posedge HCLK); #1;
    checks++;
    if (hreadyout[2] !== 1'b0) begin
      errors++;
      $display("FAIL mid_wait: ready=%b expected 0", hreadyout[2]);
    end
    #2 HRESETn = 1'b0;
    #1;
    checks++;
    if (hreadyout[2] !== 1'b1 || hresp[2] !== 1'b0 || hrdata[2] !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: ready/resp/rdata=%b/%b/0x%08h expected 1/0/0x00000000",
               hreadyout[2], hresp[2], hrdata[2]);
    end
    @(posedge HCLK); #3;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    q.delete();
    q.push_back(mk(1'b1, 2'b10, 1'b0, 32'h1F4, 32'h0));
    run(2, q);
  endtask

  task automatic test_random();
    for (int d = 0; d < 3; d++) begin
      xfer_t q[$];
      bit    kp [256];
      for (int w = 0; w < 256; w++) kp[w] = known[d][w];
      for (int n = 0; n < 40; n++) begin
        int unsigned r;
        logic [31:0] a;
        logic [7:0]  w;
        r = $urandom_range(0, 9);
        w = 8'(8'h7C + $urandom_range(0, 7));
        a = {22'd0, w, 2'b00};
        if (r == 0) begin
          q.push_back(mk(1'b1, 2'b00, 1'b0, a, 32'h0));
        end else if (r == 1) begin
          q.push_back(mk(1'b1, 2'b01, 1'b1, a, $urandom));
        end else if (r == 2) begin
          q.push_back(mk(1'b0, 2'b10, 1'b1, a, $urandom));
        end else if (r == 3) begin
          if ($urandom_range(0, 1) == 0) a = 32'h400 + ($urandom & 32'h0000FFFC);
          else a = 32'h1F0 | 32'($urandom_range(1, 3));
          q.push_back(mk(1'b1, 2'b10, 1'($urandom_range(0, 1)), a, $urandom));
        end else if (!kp[w] || $urandom_range(0, 1) == 0) begin
          q.push_back(mk(1'b1, 2'($urandom_range(2, 3)), 1'b1, a, $urandom));
          kp[w] = 1'b1;
        end else begin
          q.push_back(mk(1'b1, 2'($urandom_range(2, 3)), 1'b0, a, 32'h0));
        end
      end
      run(d, q);
    end
  endtask

  initial begin
    checks = 0; errors = 0; sel = 0;
    hsel = 3'b000; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'd0; HWDATA = 32'd0;
    HRESETn = 1'b0;
    test_reset();
    test_basic();
    test_forward();
    test_wait();
    test_burst();
    test_error();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
